hyperbus_trans_arb: RTL and testbench

//  Arbitrates AXI read (AR) and write (AW) address requests onto the single HyperBus PHY command port.

---
 rtl/hyperbus_trans_arb.sv | 138 +++++++++++++
 tb/tb_hyperbus_trans_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_trans_arb.sv
// hyperbus_trans_arb: round-robin AR/AW arbiter feeding the HyperBus PHY
// command port with one transaction in flight at a time.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ar_*_i / ar_ready_o          AXI read address request and accept
//   aw_*_i / aw_ready_o          AXI write address request and accept
//   trans_*_o / trans_ready_i    PHY command handshake and fields
//   cfg_valid_o/addr_o/size_o    one-cycle config strobe to splitter/packer
//   rd_done_i, wr_done_i         burst completion per direction
//   busy_o                       command captured or in flight
//   timeout_o                    one-cycle pulse on watchdog expiry
module hyperbus_trans_arb #(
    parameter int AddrWidth      = 32,
    parameter int BurstLength    = 8,
    parameter int SplitAddrWidth = 3,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AddrWidth-1:0]      ar_addr_i,
    input  logic [BurstLength-1:0]    ar_len_i,
    input  logic [2:0]                ar_size_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AddrWidth-1:0]      aw_addr_i,
    input  logic [BurstLength-1:0]    aw_len_i,
    input  logic [2:0]                aw_size_i,
    output logic                      trans_valid_o,
    input  logic                      trans_ready_i,
    output logic [AddrWidth-1:0]      trans_addr_o,
    output logic [BurstLength-1:0]    trans_len_o,
    output logic                      trans_write_o,
    output logic                      cfg_valid_o,
    output logic [SplitAddrWidth-1:0] cfg_addr_o,
    output logic [2:0]                cfg_size_o,
    input  logic                      rd_done_i,
    input  logic                      wr_done_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int TimerWidth =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TimerWidth-1:0] TimerLast =
        TimerWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam bit WdogEn = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                  r_state;
    logic                    r_rr;     // 0: read favoured, 1: write favoured
    logic [AddrWidth-1:0]    r_addr;
    logic [BurstLength-1:0]  r_len;
    logic [2:0]              r_size;
    logic                    r_write;
    logic [TimerWidth-1:0]   r_timer;

    logic w_idle;
    logic w_gnt_rd;
    logic w_gnt_wr;
    logic w_trans_hs;
    logic w_done;
    logic w_expire;

    assign w_idle   = (r_state == S_IDLE);
    // Read wins when alone or when both request and read is favoured.
    assign w_gnt_rd = ar_valid_i && (!aw_valid_i || !r_rr);
    assign w_gnt_wr = aw_valid_i && !w_gnt_rd;

    assign w_trans_hs = (r_state == S_ISSUE) && trans_ready_i;
    // Only the completion of the direction in flight counts.
    assign w_done     = (r_state == S_WAIT) &&
                        (r_write ? wr_done_i : rd_done_i);
    assign w_expire   = WdogEn && (r_state == S_WAIT) &&
                        (r_timer == TimerLast) && !w_done;

    assign ar_ready_o    = w_idle && w_gnt_rd;
    assign aw_ready_o    = w_idle && w_gnt_wr;
    assign trans_valid_o = (r_state == S_ISSUE);
    assign trans_addr_o  = r_addr;
    assign trans_len_o   = r_len;
    assign trans_write_o = r_write;
    assign cfg_valid_o   = w_trans_hs;
    assign cfg_addr_o    = r_addr[SplitAddrWidth-1:0];
    assign cfg_size_o    = r_size;
    assign busy_o        = !w_idle;
    assign timeout_o     = w_expire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_timer <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_rd || w_gnt_wr) begin
                        r_addr  <= w_gnt_rd ? ar_addr_i : aw_addr_i;
                        r_len   <= w_gnt_rd ? ar_len_i  : aw_len_i;
                        r_size  <= w_gnt_rd ? ar_size_i : aw_size_i;
                        r_write <= w_gnt_wr;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (trans_ready_i) begin
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_rr    <= !r_write;
                        r_state <= S_IDLE;
                    end else if (w_expire) begin
                        r_rr    <= !r_rr;
                        r_state <= S_IDLE;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_trans_arb.sv
// Bench for hyperbus_trans_arb: scoreboard of accepted requests checked
// against PHY command handshakes, plus directed arbitration/timeout cases.
module tb_hyperbus_trans_arb;

    logic        clk;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic        trans_valid;
    logic        trans_ready;
    logic [31:0] trans_addr;
    logic [7:0]  trans_len;
    logic        trans_write;
    logic        cfg_valid;
    logic [2:0]  cfg_addr;
    logic [2:0]  cfg_size;
    logic        rd_done;
    logic        wr_done;
    logic        busy;
    logic        timeout;

    hyperbus_trans_arb #(
        .AddrWidth(32),
        .BurstLength(8),
        .SplitAddrWidth(3),
        .TimeoutCycles(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ar_valid_i(ar_valid),
        .ar_ready_o(ar_ready),
        .ar_addr_i(ar_addr),
        .ar_len_i(ar_len),
        .ar_size_i(ar_size),
        .aw_valid_i(aw_valid),
        .aw_ready_o(aw_ready),
        .aw_addr_i(aw_addr),
        .aw_len_i(aw_len),
        .aw_size_i(aw_size),
        .trans_valid_o(trans_valid),
        .trans_ready_i(trans_ready),
        .trans_addr_o(trans_addr),
        .trans_len_o(trans_len),
        .trans_write_o(trans_write),
        .cfg_valid_o(cfg_valid),
        .cfg_addr_o(cfg_addr),
        .cfg_size_o(cfg_size),
        .rd_done_i(rd_done),
        .wr_done_i(wr_done),
        .busy_o(busy),
        .timeout_o(timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        wr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard: push on AR/AW accept, pop and compare on cfg strobe.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (ar_valid && ar_ready)
                q.push_back('{ar_addr, ar_len, ar_size, 1'b0});
            if (aw_valid && aw_ready)
                q.push_back('{aw_addr, aw_len, aw_size, 1'b1});
            if (ar_ready && aw_ready)
                chk("one_ready", 64'(ar_ready & aw_ready), 64'd0);
            if (cfg_valid) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 64'd0, 64'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_tvalid", 64'(trans_valid), 64'd1);
                    chk("sb_addr", 64'(trans_addr), 64'(e.addr));
                    chk("sb_len", 64'(trans_len), 64'(e.len));
                    chk("sb_write", 64'(trans_write), 64'(e.wr));
                    chk("sb_cfg_addr", 64'(cfg_addr), 64'(e.addr[2:0]));
                    chk("sb_cfg_size", 64'(cfg_size), 64'(e.size));
                end
            end
        end
    end

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0;
        aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0;
        trans_ready = 0; rd_done = 0; wr_done = 0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        step();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalid", 64'(trans_valid), 64'd0);
        chk("rst_cfg", 64'(cfg_valid), 64'd0);
        chk("rst_taddr", 64'(trans_addr), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);

        // Single read, minimum latency
        step();
        ar_valid = 1; ar_addr = 32'h1004; ar_len = 3; ar_size = 2;
        trans_ready = 1;
        #1;
        chk("t1_ar_ready", 64'(ar_ready), 64'd1);
        chk("t1_aw_ready", 64'(aw_ready), 64'd0);
        step();
        ar_valid = 0;
        #1;
        chk("t1_tvalid", 64'(trans_valid), 64'd1);
        chk("t1_cfg", 64'(cfg_valid), 64'd1);
        chk("t1_cfg_addr", 64'(cfg_addr), 64'd4);
        chk("t1_write", 64'(trans_write), 64'd0);
        step();
        #1;
        chk("t1_busy_wait", 64'(busy), 64'd1);
        chk("t1_tvalid_wait", 64'(trans_valid), 64'd0);
        step();
        rd_done = 1;
        step();
        rd_done = 0;
        #1;
        chk("t1_idle", 64'(busy), 64'd0);

        // Both valid continuously: R, W, R, W
        do_reset();
        for (int g = 0; g < 4; g++) begin
            logic exp_rd;
            exp_rd = (g % 2 == 0);
            step();
            rd_done = 0; wr_done = 0;
            ar_valid = 1; aw_valid = 1; trans_ready = 1;
            ar_addr = 32'h1000_0000 + 32'(g * 16 + g);
            aw_addr = 32'h2000_0000 + 32'(g * 32 + g + 2);
            ar_len = 8'(g + 1); aw_len = 8'(g + 9);
            ar_size = 3'(g); aw_size = 3'(g + 3);
            #1;
            chk("rr_ar_ready", 64'(ar_ready), 64'(exp_rd));
            chk("rr_aw_ready", 64'(aw_ready), 64'(!exp_rd));
            step();
            #1;
            chk("rr_cfg", 64'(cfg_valid), 64'd1);
            chk("rr_no_ready", 64'(ar_ready | aw_ready), 64'd0);
            step();
            step();
            rd_done = exp_rd;
            wr_done = !exp_rd;
        end
        step();
        ar_valid = 0; aw_valid = 0; rd_done = 0; wr_done = 0;
        #1;
        chk("rr_idle", 64'(busy), 64'd0);

        // PHY back-pressure in Issue
        step();
        ar_valid = 1; ar_addr = 32'hABCD_EF05; ar_len = 15; ar_size = 1;
        trans_ready = 0;
        #1;
        chk("bp_ar_ready", 64'(ar_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            ar_addr = 32'h0; ar_len = 0;
            #1;
            chk("bp_tvalid", 64'(trans_valid), 64'd1);
            chk("bp_cfg", 64'(cfg_valid), 64'd0);
            chk("bp_taddr", 64'(trans_addr), 64'hABCD_EF05);
            chk("bp_tlen", 64'(trans_len), 64'd15);
        end
        step();
        ar_valid = 0;
        trans_ready = 1;
        #1;
        chk("bp_cfg_hs", 64'(cfg_valid), 64'd1);
        step();
        rd_done = 1;
        step();
        rd_done = 0;
        #1;
        chk("bp_idle", 64'(busy), 64'd0);

        // Watchdog expiry, then done in the expiry cycle
        for (int pass = 0; pass < 2; pass++) begin
            step();
            aw_valid = 1; aw_addr = 32'h2000_0003; aw_len = 7; aw_size = 3;
            #1;
            chk("wd_aw_ready", 64'(aw_ready), 64'd1);
            step();
            aw_valid = 0;
            #1;
            chk("wd_cfg", 64'(cfg_valid), 64'd1);
            for (int k = 1; k <= 16; k++) begin
                step();
                wr_done = (pass == 1) && (k == 16);
                #1;
                if (pass == 0)
                    chk("wd_pulse", 64'(timeout), 64'(k == 16));
                else
                    chk("wd_suppr", 64'(timeout), 64'd0);
            end
            step();
            wr_done = 0;
            #1;
            chk("wd_idle", 64'(busy), 64'd0);
            chk("wd_one_pulse", 64'(timeout), 64'd0);
        end

        // Read in flight ignores write completion
        step();
        ar_valid = 1; ar_addr = 32'h0000_5557; ar_len = 1; ar_size = 0;
        #1;
        chk("ig_ar_ready", 64'(ar_ready), 64'd1);
        step();
        ar_valid = 0;
        step();
        wr_done = 1;
        step();
        wr_done = 0;
        #1;
        chk("ig_busy", 64'(busy), 64'd1);
        step();
        rd_done = 1; wr_done = 1;
        step();
        rd_done = 0; wr_done = 0;
        #1;
        chk("ig_idle", 64'(busy), 64'd0);

        // Reset while waiting; next grant returns to read
        step();
        aw_valid = 1; aw_addr = 32'h3000_0006; aw_len = 2; aw_size = 2;
        #1;
        chk("rw_aw_ready", 64'(aw_ready), 64'd1);
        step();
        aw_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_tvalid", 64'(trans_valid), 64'd0);
        chk("rw_taddr", 64'(trans_addr), 64'd0);
        chk("rw_tlen", 64'(trans_len), 64'd0);
        chk("rw_twrite", 64'(trans_write), 64'd0);
        chk("rw_cfg_size", 64'(cfg_size), 64'd0);
        chk("rw_timeout", 64'(timeout), 64'd0);
        ar_valid = 1; ar_addr = 32'h4000_0001; ar_len = 4; ar_size = 1;
        aw_valid = 1; aw_addr = 32'h5000_0002; aw_len = 5; aw_size = 2;
        #1;
        chk("rw_rd_first", 64'(ar_ready), 64'd1);
        chk("rw_wr_wait", 64'(aw_ready), 64'd0);
        step();
        ar_valid = 0; aw_valid = 0;
        step();
        step();
        rd_done = 1;
        step();
        rd_done = 0;
        #1;
        chk("rw_idle", 64'(busy), 64'd0);
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
